// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// MemoryModesPackage
// Shared memory-mode encoding (ReadWriteModes), the load/store unit state
// encoding (LsuState), and the byte-lane mask constants used to merge partial
// word loads (WORDLEFT / WORDRIGHT) with the old destination register value.
//
// Lane masks: bit b set means byte lane b (bits 8b+7:8b) comes from memory,
// cleared means it comes from the old register value. Each 16-bit constant
// packs four 4-bit masks, indexed by the byte offset o = addr[1:0].
// -----------------------------------------------------------------------------
package MemoryModesPackage;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        BYTE      = 3'd1,
        HALFWORD  = 3'd2,
        WORD      = 3'd3,
        WORDLEFT  = 3'd4,
        WORDRIGHT = 3'd5
    } ReadWriteModes;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } LsuState;

    // WORDLEFT: top o+1 bytes from memory. Packed as {o=3, o=2, o=1, o=0}.
    localparam logic [15:0] LANE_MASK_LEFT  = {4'b1111, 4'b1110, 4'b1100, 4'b1000};
    // WORDRIGHT: low 4-o bytes from memory. Packed as {o=3, o=2, o=1, o=0}.
    localparam logic [15:0] LANE_MASK_RIGHT = {4'b0001, 4'b0011, 4'b0111, 4'b1111};
    // Every other mode passes the whole memory word through.
    localparam logic [3:0]  LANE_MASK_ALL   = 4'b1111;

    function automatic logic [3:0] lane_mask(input logic [2:0] mode,
                                             input logic [1:0] offset);
        logic [3:0] mask;
        mask = LANE_MASK_ALL;
        if (mode == WORDLEFT) begin
            mask = LANE_MASK_LEFT[{offset, 2'b00} +: 4];
        end else if (mode == WORDRIGHT) begin
            mask = LANE_MASK_RIGHT[{offset, 2'b00} +: 4];
        end
        return mask;
    endfunction

    // True for the five modes that actually touch memory.
    function automatic logic is_access_mode(input logic [2:0] mode);
        logic ok;
        ok = 1'b0;
        case (mode)
            BYTE, HALFWORD, WORD, WORDLEFT, WORDRIGHT: ok = 1'b1;
            default:                                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] mode,
                                           input logic [1:0] offset);
        return ((mode == HALFWORD) && offset[0]) ||
               ((mode == WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_lane_merge.sv
// -----------------------------------------------------------------------------
// lsu_lane_merge
// Combinational byte-lane merge of a memory read word with the old
// destination register. WORDLEFT/WORDRIGHT select a subset of lanes from
// memory according to the byte offset; every other mode passes memory through.
//
// Ports:
//   i_mode      3   ReadWriteModes value of the load
//   i_offset    2   byte offset (address[1:0])
//   i_mem_data  32  word returned by memory
//   i_rt_old    32  old destination register value
//   o_data      32  merged load result
// -----------------------------------------------------------------------------
module lsu_lane_merge
    import MemoryModesPackage::*;
(
    input  logic [2:0]  i_mode,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_mem_data,
    input  logic [31:0] i_rt_old,
    output logic [31:0] o_data
);

    logic [3:0] w_mask;

    assign w_mask = lane_mask(i_mode, i_offset);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            assign o_data[gi*8 +: 8] = w_mask[gi] ? i_mem_data[gi*8 +: 8]
                                                  : i_rt_old[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding load/store sequencer between a pipeline request/response
// handshake and a simple synchronous memory port (read data valid one clock
// after the read is issued).
//
// Sequence: IDLE -> ISSUE -> WAIT -> RESP (load)
//           IDLE -> ISSUE -> RESP         (store)
//           IDLE -> RESP                  (mode NONE, or trapped misalignment)
//
// Parameters:
//   ADDR_BITS         low address bits forwarded to memory (rest driven 0)
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned HALFWORD/WORD requests are
//                         not issued and respond with resp_error = 1.
//                         When undefined, resp_error is constant 0.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write, req_mode,
//   req_unsigned, req_address,
//   req_wdata, req_rt_old          request fields, latched on acceptance
//   resp_valid/resp_ready          response handshake
//   resp_rdata, resp_error         load result (0 for stores), error flag
//   mem_address, mem_data,
//   mem_writeMode, mem_readMode,
//   mem_unsignedLoad               memory request outputs
//   mem_dataOutput                 memory read data
// -----------------------------------------------------------------------------
module load_store_unit
    import MemoryModesPackage::*;
#(
    parameter int ADDR_BITS = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_mode,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic [2:0]  mem_writeMode,
    output logic [2:0]  mem_readMode,
    output logic        mem_unsignedLoad,
    input  logic [31:0] mem_dataOutput
);

    localparam logic [31:0] ADDR_MASK = (ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << ADDR_BITS) - 32'd1);

    LsuState     r_state;
    LsuState     w_state_next;
    logic        r_write;
    logic [2:0]  r_mode;
    logic        r_unsigned;
    logic [31:0] r_address;
    logic [31:0] r_wdata;
    logic [31:0] r_rt_old;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_req_noop;
    logic        w_req_trap;
    logic [31:0] w_merged;

    assign w_accept   = req_valid && (r_state == IDLE);
    // Unknown encodings are treated the same as NONE: no memory access.
    assign w_req_noop = !is_access_mode(req_mode);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_req_trap = is_misaligned(req_mode, req_address[1:0]);
`else
    assign w_req_trap = 1'b0;
`endif

    lsu_lane_merge u_lane_merge (
        .i_mode     (r_mode),
        .i_offset   (r_address[1:0]),
        .i_mem_data (mem_dataOutput),
        .i_rt_old   (r_rt_old),
        .o_data     (w_merged)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_req_noop || w_req_trap) ? RESP : ISSUE;
                end
            end
            ISSUE:   w_state_next = r_write ? RESP : WAIT;
            WAIT:    w_state_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------ request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_mode     <= NONE;
            r_unsigned <= 1'b0;
            r_address  <= '0;
            r_wdata    <= '0;
            r_rt_old   <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_write    <= req_write;
                r_mode     <= req_mode;
                r_unsigned <= req_unsigned;
                r_address  <= req_address;
                r_wdata    <= req_wdata;
                r_rt_old   <= req_rt_old;
                // Stores, no-ops and traps respond with 0; loads overwrite in WAIT.
                r_rdata    <= '0;
            end else if (r_state == WAIT) begin
                r_rdata    <= w_merged;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= w_req_trap;
        end
    end

    assign resp_error = (r_state == RESP) && r_error;
`else
    assign resp_error = 1'b0;
`endif

    // ------------------------------------------------------------ outputs
    always_comb begin
        req_ready        = (r_state == IDLE);
        resp_valid       = (r_state == RESP);
        resp_rdata       = (r_state == RESP) ? r_rdata : '0;
        mem_address      = '0;
        mem_data         = '0;
        mem_writeMode    = NONE;
        mem_readMode     = NONE;
        mem_unsignedLoad = 1'b0;
        case (r_state)
            ISSUE: begin
                mem_address      = r_address & ADDR_MASK;
                mem_data         = r_wdata;
                mem_unsignedLoad = r_unsigned;
                if (r_write) begin
                    mem_writeMode = r_mode;
                end else begin
                    mem_readMode  = r_mode;
                end
            end
            WAIT: begin
                // Memory samples address/sign control while returning data.
                mem_address      = r_address & ADDR_MASK;
                mem_unsignedLoad = r_unsigned;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench: each transaction pushes its expected response (data,
// error, latency, whether memory is touched) when driven; the entry is popped
// and compared when resp_valid is observed. Memory read data is driven only
// in the cycle after the read is issued; other cycles carry a poison value.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam logic [31:0] POISON = 32'hBAD0_BAD0;
    localparam int          AB     = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_mode;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic [31:0] req_rt_old;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic [2:0]  mem_writeMode;
    logic [2:0]  mem_readMode;
    logic        mem_unsignedLoad;
    logic [31:0] mem_dataOutput;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_BITS(AB)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_mode         (req_mode),
        .req_unsigned     (req_unsigned),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .req_rt_old       (req_rt_old),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .mem_writeMode    (mem_writeMode),
        .mem_readMode     (mem_readMode),
        .mem_unsignedLoad (mem_unsignedLoad),
        .mem_dataOutput   (mem_dataOutput)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        issue;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: WORDLEFT takes bytes 3-o..3 from memory, WORDRIGHT bytes 0..3-o.
    function automatic logic [31:0] ref_merge(input logic [2:0] mode,
                                              input logic [1:0] o,
                                              input logic [31:0] memv,
                                              input logic [31:0] rt);
        logic [31:0] r;
        r = memv;
        for (int b = 0; b < 4; b++) begin
            if (mode == 3'd4 && b < 3 - int'(o)) r[b*8 +: 8] = rt[b*8 +: 8];
            if (mode == 3'd5 && b > 3 - int'(o)) r[b*8 +: 8] = rt[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic exp_t model(input logic wr, input logic [2:0] mode,
                                   input logic [31:0] addr, input logic [31:0] rt,
                                   input logic [31:0] memv);
        exp_t e;
        logic acc;
        logic trap;
        acc  = (mode >= 3'd1) && (mode <= 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (mode == 3'd2 && addr[0]) || (mode == 3'd3 && addr[1:0] != 2'b00);
`else
        trap = 1'b0;
`endif
        e.err   = trap;
        e.issue = acc && !trap;
        if (!e.issue) begin
            e.lat   = 0;
            e.rdata = 32'h0;
        end else if (wr) begin
            e.lat   = 1;
            e.rdata = 32'h0;
        end else begin
            e.lat   = 2;
            e.rdata = ref_merge(mode, addr[1:0], memv, rt);
        end
        return e;
    endfunction

    task automatic run_txn(input string name, input logic wr, input logic [2:0] mode,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rt,
                           input logic [31:0] memv, input int stall);
        exp_t e;
        exp_t m;
        int   lat;
        m = model(wr, mode, addr, rt, memv);
        sb_q.push_back(m);

        @(negedge clk);
        check_eq({name, ":req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_mode     = mode;
        req_unsigned = uns;
        req_address  = addr;
        req_wdata    = wdata;
        req_rt_old   = rt;
        resp_ready   = 1'b0;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_address  = 32'hFFFF_FFFF;
        req_wdata    = 32'hFFFF_FFFF;

        lat = 0;
        while (!resp_valid && lat < 8) begin
            if (lat == 0) begin
                check_eq({name, ":issue_wmode"}, {29'd0, mem_writeMode}, wr ? {29'd0, mode} : 32'd0);
                check_eq({name, ":issue_rmode"}, {29'd0, mem_readMode},  wr ? 32'd0 : {29'd0, mode});
                check_eq({name, ":issue_addr"},  mem_address, addr & ((32'd1 << AB) - 32'd1));
                check_eq({name, ":issue_data"},  mem_data, wdata);
                check_eq({name, ":issue_uns"},   {31'd0, mem_unsignedLoad}, {31'd0, uns});
            end else if (lat == 1) begin
                check_eq({name, ":wait_modes"}, {26'd0, mem_writeMode, mem_readMode}, 32'd0);
                check_eq({name, ":wait_addr"},  mem_address, addr & ((32'd1 << AB) - 32'd1));
                mem_dataOutput = memv;
            end
            @(posedge clk); #1;
            mem_dataOutput = POISON;
            lat++;
        end
        check_eq({name, ":latency"}, lat, m.lat);

        if (sb_q.size() == 0) begin
            check_eq({name, ":sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq({name, ":resp_valid"}, {31'd0, resp_valid}, 32'd1);
            check_eq({name, ":rdata"},      resp_rdata, e.rdata);
            check_eq({name, ":error"},      {31'd0, resp_error}, {31'd0, e.err});
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                check_eq({name, ":stall_valid"}, {31'd0, resp_valid}, 32'd1);
                check_eq({name, ":stall_rdata"}, resp_rdata, e.rdata);
                check_eq({name, ":stall_error"}, {31'd0, resp_error}, {31'd0, e.err});
                check_eq({name, ":stall_modes"}, {26'd0, mem_writeMode, mem_readMode}, 32'd0);
            end
            $display("[TB] txn %s wr=%0b mode=%0d addr=0x%08h rdata=0x%08h err=%0b lat=%0d",
                     name, wr, mode, addr, resp_rdata, resp_error, lat);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_eq({name, ":back_idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] r;
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_mode       = 3'd0;
        req_unsigned   = 1'b0;
        req_address    = 32'h0;
        req_wdata      = 32'h0;
        req_rt_old     = 32'h0;
        resp_ready     = 1'b0;
        mem_dataOutput = POISON;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ready",  {31'd0, req_ready}, 32'd1);
        check_eq("reset_valid",  {31'd0, resp_valid}, 32'd0);
        check_eq("reset_rdata",  resp_rdata, 32'd0);
        check_eq("reset_error",  {31'd0, resp_error}, 32'd0);
        check_eq("reset_addr",   mem_address, 32'd0);
        check_eq("reset_data",   mem_data, 32'd0);
        check_eq("reset_modes",  {25'd0, mem_unsignedLoad, mem_writeMode, mem_readMode}, 32'd0);
        rst = 1'b0;

        run_txn("ld_word",      1'b0, 3'd3, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         32'hDEAD_BEEF, 0);
        run_txn("st_byte",      1'b1, 3'd1, 1'b0, 32'h0000_0003, 32'h0000_00AB, 32'h0,         32'h0,         0);
        run_txn("ld_wordleft",  1'b0, 3'd4, 1'b0, 32'h0000_0005, 32'h0,         32'hAAAA_BBCC, 32'h1122_0000, 0);
        run_txn("ld_wordright", 1'b0, 3'd5, 1'b0, 32'h0000_0006, 32'h0,         32'h5566_AABB, 32'h0000_3344, 0);
        run_txn("ld_half_hi",   1'b0, 3'd2, 1'b1, 32'hABCD_0012, 32'h0,         32'h0,         32'h0000_F00D, 0);
        run_txn("nop",          1'b0, 3'd0, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'h0,         32'h0,         1);
        run_txn("ld_word_mis",  1'b0, 3'd3, 1'b0, 32'h0000_0002, 32'h0,         32'h0,         32'h1234_5678, 1);
        run_txn("st_half_mis",  1'b1, 3'd2, 1'b0, 32'h0000_0001, 32'h0000_BEEF, 32'h0,         32'h0,         0);
        run_txn("st_word",      1'b1, 3'd3, 1'b0, 32'h0001_FFFC, 32'hCAFE_F00D, 32'h0,         32'h0,         2);

        for (int o = 0; o < 4; o++) begin
            d = $urandom;
            r = $urandom;
            run_txn("ld_wl_sweep", 1'b0, 3'd4, 1'b0, 32'h100 + o, 32'h0, r, d, 0);
            d = $urandom;
            r = $urandom;
            run_txn("ld_wr_sweep", 1'b0, 3'd5, 1'b0, 32'h200 + o, 32'h0, r, d, 0);
        end

        // Stalled response held for five cycles.
        run_txn("ld_stall", 1'b0, 3'd3, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 32'h0BAD_F00D, 5);

        // Second load reset while in WAIT: discarded, no response.
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_mode    = 3'd3;
        req_address = 32'h0000_0024;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_wait_addr", mem_address, 32'h0000_0024);
        mem_dataOutput = 32'h7777_7777;
        rst = 1'b1;
        #1;
        check_eq("rst_async_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_async_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_async_addr",  mem_address, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_dataOutput = POISON;
        resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check_eq("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        resp_ready = 1'b0;
        $display("[TB] txn rst_in_wait discarded");

        run_txn("ld_after_rst", 1'b0, 3'd1, 1'b0, 32'h0000_0031, 32'h0, 32'h0, 32'h0000_0042, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16: number of low address bits forwarded to memory; upper bits are driven 0.
REQ-002 SHALL have one clock and an asynchronous active-high reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  pipeline request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_mode  input  3  ReadWriteModes value: BYTE, HALFWORD, WORD, WORDLEFT or WORDRIGHT.
REQ-009 req_unsigned  input  1  zero-extend a BYTE or HALFWORD load.
REQ-010 req_address  input  32  byte address.
REQ-011 req_wdata  input  32  store data.
REQ-012 req_rt_old  input  32  old destination register value, used by the WORDLEFT/WORDRIGHT merge.
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  pipeline accepts the response.
REQ-015 resp_rdata  output  32  load result; 0 for stores.
REQ-016 resp_error  output  1  misaligned access flag (see Configuration).
REQ-017 mem_address, mem_data  output  32 each  memory request address and data.
REQ-018 mem_writeMode, mem_readMode  output  3 each  memory modes.
REQ-019 mem_unsignedLoad  output  1  memory sign-control input.
REQ-020 mem_dataOutput  input  32  memory read data, valid one clk after the read is issued.

Function
REQ-021 The state machine SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid && req_ready at a clock edge, and all req_* fields SHALL be latched at that edge.
REQ-023 From IDLE, an accepted request SHALL move the machine to ISSUE.
REQ-024 ISSUE SHALL last exactly one cycle and drive mem_address = {0, latched address[ADDR_BITS-1:0]}, mem_data = latched wdata, and mem_writeMode or mem_readMode = latched mode (the other = NONE).
REQ-025 ISSUE SHALL go to WAIT for a load and to RESP for a store.
REQ-026 In WAIT, modes SHALL be NONE and mem_address and mem_unsignedLoad SHALL be held from ISSUE.
REQ-027 At the end of WAIT, the unit SHALL capture the merged result into resp_rdata and go to RESP.
REQ-028 Outside ISSUE and WAIT, mem_* outputs SHALL be 0 and modes SHALL be NONE.
REQ-029 Load merge: BYTE, HALFWORD and WORD SHALL pass mem_dataOutput through.
REQ-030 Load merge: WORDLEFT with offset o = addr[1:0] SHALL take the top o+1 bytes from memory and the remaining low bytes from rt_old.
REQ-031 Load merge: WORDRIGHT SHALL take the low 4-o bytes from memory and the remaining high bytes from rt_old.
REQ-032 In RESP, resp_valid SHALL be 1, with resp_rdata and resp_error stable.
REQ-033 RESP SHALL go to IDLE when resp_ready is 1; with no bubble required, the next request may be accepted on the following edge.
REQ-034 Latency from acceptance edge to resp_valid SHALL be 2 cycles for a load and 1 cycle for a store.
REQ-035 A stalled response (resp_ready = 0) SHALL hold indefinitely with no new memory access.
REQ-036 req_mode NONE SHALL be accepted as a no-op: no memory access, RESP after 1 cycle, resp_rdata 0.

Reset
REQ-037 While rst is asserted, the state SHALL be IDLE and all outputs SHALL be 0, with req_ready 1 and modes NONE.
REQ-038 Reset mid-operation SHALL discard the in-flight request without a response; a write issued before reset is not rolled back.

Configuration
REQ-039 The macro LSU_MISALIGN_TRAP_EN SHALL control misaligned-access trapping.
REQ-040 With LSU_MISALIGN_TRAP_EN defined, HALFWORD with addr[0] = 1, or WORD with addr[1:0] != 0, SHALL skip ISSUE and WAIT and go directly to RESP with resp_error 1 and resp_rdata 0.
REQ-041 Without LSU_MISALIGN_TRAP_EN, misaligned requests SHALL be issued unchanged and resp_error SHALL be constant 0.

Structure
REQ-042 ReadWriteModes SHALL be reused from MemoryModesPackage.
REQ-043 The LsuState enum and the byte-lane mask constants SHALL be added to the same package.
REQ-044 The combinational WORDLEFT/WORDRIGHT lane merge SHALL be the sub-module lsu_lane_merge.

Verification
REQ-045 Load WORD at 0x0010 with memory returning 0xDEADBEEF -> mem_readMode = WORD for one cycle; resp_valid 2 cycles after acceptance; resp_rdata 0xDEADBEEF.
REQ-046 Store BYTE 0x000000AB at 0x0003 -> one ISSUE cycle with mem_writeMode BYTE and mem_address 0x0003; resp_valid the next cycle; resp_rdata 0.
REQ-047 WORDLEFT at 0x0005 (o = 1), memory returns 0x11220000, rt_old 0xAAAABBCC -> resp_rdata 0x1122BBCC.
REQ-048 WORDRIGHT at 0x0006 (o = 2), memory returns 0x00003344, rt_old 0x5566AABB -> resp_rdata 0x55663344.
REQ-049 With LSU_MISALIGN_TRAP_EN, WORD load at 0x0002 -> no mem mode asserted; resp_error 1 after 1 cycle.
REQ-050 resp_ready held 0 for 5 cycles, then rst pulsed during WAIT of a second load -> response held stable for all 5 cycles; reset returns the unit to IDLE with no resp_valid.
